// File: rtl/iir_1_mc.sv
// Multi-channel first-order IIR filter: y(n) = a*y(n-1) + b*x(n) per channel,
// one shared multiplier pair, saturating output, runtime-loadable coefficients.
module iir_1_mc #(
   parameter int DATA_W   = 8,
   parameter int COEF_W   = 4,
   parameter int OUT_W    = 18,
   parameter int CHANNELS = 2,
   parameter int A_INIT   = -2,
   parameter int B_INIT   = 3,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     coef_load,
   input  logic signed [COEF_W-1:0] coef_a,
   input  logic signed [COEF_W-1:0] coef_b,
   input  logic                     in_valid,
   input  logic        [CH_W-1:0]   in_ch,
   input  logic signed [DATA_W-1:0] x,
   output logic                     out_valid,
   output logic        [CH_W-1:0]   out_ch,
   output logic signed [OUT_W-1:0]  y,
   output logic                     out_sat,
   output logic                     sat_sticky
);

   // Wide enough to hold a*y_prev + b*x exactly before saturating.
   localparam int ACC_W = OUT_W + COEF_W + 1;
   localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);
   localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
   localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

   logic signed [COEF_W-1:0] r_a;
   logic signed [COEF_W-1:0] r_b;
   logic signed [OUT_W-1:0]  r_yPrev [CHANNELS];
   logic                     r_outValid;
   logic        [CH_W-1:0]   r_outCh;
   logic signed [OUT_W-1:0]  r_y;
   logic                     r_outSat;
   logic                     r_satSticky;

   logic                     w_accept;
   logic signed [OUT_W-1:0]  w_yOld;
   logic signed [ACC_W-1:0]  w_aExt;
   logic signed [ACC_W-1:0]  w_bExt;
   logic signed [ACC_W-1:0]  w_yExt;
   logic signed [ACC_W-1:0]  w_xExt;
   logic signed [ACC_W-1:0]  w_acc;
   logic                     w_ovf;
   logic signed [OUT_W-1:0]  w_ySat;

   // Out-of-range channel indices are silently dropped.
   assign w_accept = in_valid && ({1'b0, in_ch} < CH_LIMIT);

   always_comb begin
      w_yOld = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (in_ch == CH_W'(i)) begin
            w_yOld = r_yPrev[i];
         end
      end
   end

   assign w_aExt = ACC_W'(r_a);
   assign w_bExt = ACC_W'(r_b);
   assign w_yExt = ACC_W'(w_yOld);
   assign w_xExt = ACC_W'(x);
   assign w_acc  = (w_aExt * w_yExt) + (w_bExt * w_xExt);

   // Overflow whenever the bits above the output sign are not a pure sign extension.
   assign w_ovf  = (w_acc[ACC_W-1:OUT_W-1] != {(ACC_W - OUT_W + 1){w_acc[ACC_W-1]}});
   assign w_ySat = w_ovf ? (w_acc[ACC_W-1] ? SAT_MIN : SAT_MAX) : w_acc[OUT_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a <= COEF_W'(A_INIT);
         r_b <= COEF_W'(B_INIT);
      end else if (coef_load) begin
         r_a <= coef_a;
         r_b <= coef_b;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (rst) begin
            r_yPrev[i] <= '0;
         end else if (w_accept && (in_ch == CH_W'(i))) begin
            r_yPrev[i] <= w_ySat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_outValid <= 1'b0;
         r_outCh    <= '0;
         r_y        <= '0;
         r_outSat   <= 1'b0;
      end else begin
         r_outValid <= w_accept;
         r_outSat   <= w_accept && w_ovf;
         if (w_accept) begin
            r_outCh <= in_ch;
            r_y     <= w_ySat;
         end
      end
   end

   // A saturation in the same cycle as a coefficient load keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_satSticky <= 1'b0;
      end else if (w_accept && w_ovf) begin
         r_satSticky <= 1'b1;
      end else if (coef_load) begin
         r_satSticky <= 1'b0;
      end
   end

   assign out_valid  = r_outValid;
   assign out_ch     = r_outCh;
   assign y          = r_y;
   assign out_sat    = r_outSat;
   assign sat_sticky = r_satSticky;

endmodule

// File: tb/tb_iir_1_mc.sv
// Self-checking bench for iir_1_mc: a behavioural model pushes expected results
// into a queue as samples are driven, and each scenario pops and compares them.
module tb_iir_1_mc;

   localparam int DATA_W   = 8;
   localparam int COEF_W   = 4;
   localparam int OUT_W    = 18;
   localparam int CHANNELS = 3;
   localparam int CH_W     = 2;
   localparam longint Y_MAX = 131071;
   localparam longint Y_MIN = -131072;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     coef_load;
   logic signed [COEF_W-1:0] coef_a;
   logic signed [COEF_W-1:0] coef_b;
   logic                     in_valid;
   logic        [CH_W-1:0]   in_ch;
   logic signed [DATA_W-1:0] x;
   logic                     out_valid;
   logic        [CH_W-1:0]   out_ch;
   logic signed [OUT_W-1:0]  y;
   logic                     out_sat;
   logic                     sat_sticky;

   typedef struct {
      logic [CH_W-1:0]         ch;
      logic signed [OUT_W-1:0] yv;
      logic                    sat;
   } expT;

   expT    scoreQ[$];
   expT    e;
   longint mY [CHANNELS];
   longint mA, mB;
   logic   mSticky;
   logic   expValid;
   logic signed [OUT_W-1:0] mLastY;
   logic [CH_W-1:0]         mLastCh;
   int     nChecks = 0;
   int     nPass   = 0;

   iir_1_mc #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W),
      .CHANNELS(CHANNELS), .A_INIT(-2), .B_INIT(3)
   ) dut (
      .clk(clk), .rst(rst), .coef_load(coef_load), .coef_a(coef_a), .coef_b(coef_b),
      .in_valid(in_valid), .in_ch(in_ch), .x(x),
      .out_valid(out_valid), .out_ch(out_ch), .y(y), .out_sat(out_sat),
      .sat_sticky(sat_sticky)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Drives one cycle of stimulus, updates the reference model and pushes the
   // expected result, then returns 1 time unit after the capturing edge.
   task automatic stepSample(input logic rstIn, input logic vIn, input int chIn,
                             input int xIn, input logic loadIn,
                             input int aIn, input int bIn);
      longint acc;
      logic   sat;
      expT    n;
      rst       = rstIn;
      in_valid  = vIn;
      in_ch     = CH_W'(chIn);
      x         = DATA_W'(xIn);
      coef_load = loadIn;
      coef_a    = COEF_W'(aIn);
      coef_b    = COEF_W'(bIn);
      expValid  = 1'b0;
      if (rstIn) begin
         for (int i = 0; i < CHANNELS; i++) mY[i] = 0;
         mA = -2; mB = 3; mSticky = 1'b0;
         scoreQ.delete();
         mLastY = '0; mLastCh = '0;
      end else begin
         sat = 1'b0;
         if (vIn && chIn < CHANNELS) begin
            acc = mA * mY[chIn] + mB * longint'(xIn);
            if (acc > Y_MAX) begin acc = Y_MAX; sat = 1'b1; end
            if (acc < Y_MIN) begin acc = Y_MIN; sat = 1'b1; end
            mY[chIn] = acc;
            n.ch = CH_W'(chIn); n.yv = OUT_W'(acc); n.sat = sat;
            scoreQ.push_back(n);
            expValid = 1'b1;
            mLastY = n.yv; mLastCh = n.ch;
         end
         if (loadIn) begin
            mA = aIn; mB = bIn; mSticky = 1'b0;
         end
         if (sat) mSticky = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulusReset();
      stepSample(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
      stepSample(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
   endtask

   task automatic test_reset();
      applyStimulusReset();
      nChecks++;
      if (out_valid !== 1'b0 || y !== '0 || out_ch !== '0 || out_sat !== 1'b0 || sat_sticky !== 1'b0)
         $display("[TB] FAIL reset_state: valid=%b y=%0d ch=%0d sat=%b sticky=%b, required all zero",
                  out_valid, y, out_ch, out_sat, sat_sticky);
      else nPass++;
      // Default coefficients: x alternating 1,2 gives 3,0,3,0; then x=0 gives 0.
      for (int i = 0; i < 8; i++) begin
         stepSample(1'b0, 1'b1, 0, (i >= 6) ? 0 : ((i % 2 == 0) ? 1 : 2), 1'b0, 0, 0);
         nChecks++;
         e = scoreQ.pop_front();
         if (out_valid !== 1'b1 || y !== e.yv || y !== ((i < 6 && i % 2 == 0) ? 18'sd3 : 18'sd0) ||
             out_ch !== e.ch || out_sat !== 1'b0)
            $display("[TB] FAIL default_seq[%0d]: valid=%b y=%0d sat=%b, required valid=1 y=%0d sat=0",
                     i, out_valid, y, out_sat, e.yv);
         else nPass++;
      end
      stepSample(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
      nChecks++;
      if (out_valid !== 1'b0) $display("[TB] FAIL pulse_width: out_valid=%b, required 0", out_valid);
      else nPass++;
   endtask

   task automatic test_saturation();
      applyStimulusReset();
      for (int i = 1; i <= 18; i++) begin
         stepSample(1'b0, 1'b1, 0, 1, 1'b0, 0, 0);
         nChecks++;
         e = scoreQ.pop_front();
         if (out_valid !== 1'b1 || y !== e.yv || out_sat !== e.sat || sat_sticky !== mSticky)
            $display("[TB] FAIL sat_seq[%0d]: y=%0d sat=%b sticky=%b, required y=%0d sat=%b sticky=%b",
                     i, y, out_sat, sat_sticky, e.yv, e.sat, mSticky);
         else nPass++;
         if (i == 16 || i == 17 || i == 18) begin
            nChecks++;
            if ((i == 16 && (y !== -18'sd65535 || out_sat !== 1'b0 || sat_sticky !== 1'b0)) ||
                (i == 17 && (y !== 18'sd131071 || out_sat !== 1'b1 || sat_sticky !== 1'b1)) ||
                (i == 18 && (y !== -18'sd131072 || out_sat !== 1'b1)))
               $display("[TB] FAIL sat_boundary[%0d]: y=%0d sat=%b sticky=%b", i, y, out_sat, sat_sticky);
            else nPass++;
         end
      end
   endtask

   task automatic test_interleave();
      applyStimulusReset();
      for (int i = 0; i < 10; i++) begin
         stepSample(1'b0, 1'b1, i % 2, (i % 2 == 0) ? 1 : 2, 1'b0, 0, 0);
         nChecks++;
         e = scoreQ.pop_front();
         if (out_valid !== 1'b1 || y !== e.yv || out_ch !== e.ch || out_sat !== e.sat)
            $display("[TB] FAIL interleave[%0d]: ch=%0d y=%0d, required ch=%0d y=%0d",
                     i, out_ch, y, e.ch, e.yv);
         else nPass++;
      end
      nChecks++;
      if (mY[0] !== 64'sd33 || mY[1] !== 64'sd66)
         $display("[TB] FAIL interleave_model: ch0=%0d ch1=%0d, required 33/66", mY[0], mY[1]);
      else nPass++;
   endtask

   task automatic test_coef_load();
      applyStimulusReset();
      for (int i = 0; i < 17; i++) stepSample(1'b0, 1'b1, 2, 1, 1'b0, 0, 0);
      scoreQ.delete();
      nChecks++;
      if (sat_sticky !== 1'b1) $display("[TB] FAIL sticky_set: sticky=%b, required 1", sat_sticky);
      else nPass++;
      stepSample(1'b0, 1'b1, 0, 1, 1'b0, 0, 0);
      stepSample(1'b0, 1'b1, 0, 2, 1'b1, 1, 1);
      stepSample(1'b0, 1'b1, 0, 2, 1'b0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         e = scoreQ.pop_front();
         nChecks++;
         if (e.yv !== ((i == 0) ? 18'sd3 : (i == 1) ? 18'sd0 : 18'sd2))
            $display("[TB] FAIL coef_model[%0d]: model y=%0d", i, e.yv);
         else nPass++;
      end
      nChecks++;
      if (out_valid !== 1'b1 || y !== 18'sd2 || sat_sticky !== 1'b0)
         $display("[TB] FAIL coef_load: y=%0d sticky=%b, required y=2 sticky=0", y, sat_sticky);
      else nPass++;
      // ch2 holds 131071; with a=b=1 and x=1 it saturates while a load clears.
      stepSample(1'b0, 1'b1, 2, 1, 1'b1, 1, 1);
      e = scoreQ.pop_front();
      nChecks++;
      if (out_sat !== 1'b1 || y !== e.yv || sat_sticky !== 1'b1 || mSticky !== 1'b1)
         $display("[TB] FAIL sticky_set_wins: y=%0d sat=%b sticky=%b, required y=%0d sat=1 sticky=1",
                  y, out_sat, sat_sticky, e.yv);
      else nPass++;
   endtask

   task automatic test_invalid_and_gaps();
      applyStimulusReset();
      stepSample(1'b0, 1'b1, 1, 5, 1'b0, 0, 0);
      void'(scoreQ.pop_front());
      for (int i = 0; i < 4; i++) begin
         stepSample(1'b0, (i == 0), 3, 7, 1'b0, 0, 0);
         nChecks++;
         if (out_valid !== expValid || y !== mLastY || out_ch !== mLastCh || out_sat !== 1'b0)
            $display("[TB] FAIL gap_hold[%0d]: valid=%b y=%0d ch=%0d, required valid=0 y=%0d ch=%0d",
                     i, out_valid, y, out_ch, mLastY, mLastCh);
         else nPass++;
      end
      stepSample(1'b0, 1'b1, 1, 0, 1'b0, 0, 0);
      e = scoreQ.pop_front();
      nChecks++;
      if (out_valid !== 1'b1 || y !== e.yv || y !== -18'sd30)
         $display("[TB] FAIL invalid_no_state: y=%0d, required %0d", y, e.yv);
      else nPass++;
   endtask

   task automatic test_back_to_back_reset();
      applyStimulusReset();
      stepSample(1'b0, 1'b1, 0, 2, 1'b1, 1, 1);
      void'(scoreQ.pop_front());
      for (int i = 0; i < 3; i++) stepSample(1'b0, 1'b1, 0, 1, 1'b0, 0, 0);
      scoreQ.delete();
      stepSample(1'b1, 1'b1, 0, 1, 1'b0, 0, 0);
      nChecks++;
      if (out_valid !== 1'b0 || y !== '0 || out_ch !== '0 || out_sat !== 1'b0 || sat_sticky !== 1'b0)
         $display("[TB] FAIL mid_reset: valid=%b y=%0d ch=%0d, required 0/0/0", out_valid, y, out_ch);
      else nPass++;
      for (int i = 0; i < 3; i++) begin
         stepSample(1'b0, 1'b1, 0, 1, 1'b0, 0, 0);
         e = scoreQ.pop_front();
         nChecks++;
         if (out_valid !== 1'b1 || y !== e.yv || y !== ((i == 0) ? 18'sd3 : (i == 1) ? -18'sd3 : 18'sd9))
            $display("[TB] FAIL after_reset[%0d]: y=%0d, required %0d", i, y, e.yv);
         else nPass++;
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_ch = '0; x = '0;
      coef_load = 1'b0; coef_a = '0; coef_b = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_saturation();
      test_interleave();
      test_coef_load();
      test_invalid_and_gaps();
      test_back_to_back_reset();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
